// File: rtl/val2_shift_sequencer.sv
// rtl/val2_shift_sequencer.sv - multi-cycle ARM Val2 generator using an SPC-bit-per-cycle shifter
module val2_shift_sequencer #(
  parameter int SPC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] shifter_operand,
  input  logic        I,
  input  logic        mem_en,
  input  logic [31:0] val_Rm,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] SPC_W = 5'(SPC);

  state_t      state;
  logic [31:0] data;
  logic [4:0]  remaining;
  logic [1:0]  shift_type;

  logic        accept;
  logic [31:0] cap_data;
  logic [4:0]  cap_amount;
  logic [1:0]  cap_type;
  logic [4:0]  step;
  logic [5:0]  ror_back;
  logic [31:0] stepped;

  assign req_ready = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = req_valid & req_ready;
  assign busy      = (state != IDLE);

  // Operand decode; mem_en overrides I, which overrides the register shift.
  always_comb begin
    cap_data   = val_Rm;
    cap_amount = shifter_operand[11:7];
    cap_type   = shifter_operand[6:5];
    if (mem_en) begin
      cap_data   = {20'd0, shifter_operand};
      cap_amount = 5'd0;
      cap_type   = 2'b00;
    end else if (I) begin
      cap_data   = {24'd0, shifter_operand[7:0]};
      cap_amount = {shifter_operand[11:8], 1'b0};
      cap_type   = 2'b11;
    end
  end

  always_comb begin
    step     = (remaining < SPC_W) ? remaining : SPC_W;
    ror_back = 6'd32 - {1'b0, step};
    stepped  = data;
    case (shift_type)
      2'b00: stepped = data << step;
      2'b01: stepped = data >> step;
      2'b10: stepped = $signed(data) >>> step;
      2'b11: stepped = (data >> step) | (data << ror_back);
      default: stepped = data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      data       <= 32'd0;
      remaining  <= 5'd0;
      shift_type <= 2'b00;
      out        <= 32'd0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      data       <= cap_data;
      remaining  <= cap_amount;
      shift_type <= cap_type;
      if (cap_amount == 5'd0) begin
        out       <= cap_data;
        out_valid <= 1'b1;
        state     <= DONE;
      end else begin
        out_valid <= 1'b0;
        state     <= SHIFT;
      end
    end else begin
      case (state)
        SHIFT: begin
          data      <= stepped;
          remaining <= remaining - step;
          // Final step writes the result straight into out so DONE needs no extra cycle.
          if (remaining == step) begin
            out       <= stepped;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
